// File: rtl/regfile_mp_sb_if.sv
// regfile_mp_sb_if: write, read, reserve and scoreboard signals of the register file
interface regfile_mp_sb_if #(
  parameter int W  = 32,
  parameter int N  = 16,
  parameter int A  = $clog2(N),
  parameter int NR = 2,
  parameter int NW = 2
);
  logic [NW-1:0]   wr_en;
  logic [NW*A-1:0] wr_addr;
  logic [NW*W-1:0] wr_data;
  logic [NR*A-1:0] rd_addr;
  logic [NR*W-1:0] rd_data;
  logic [NR-1:0]   rd_busy;
  logic            rsv_en;
  logic [A-1:0]    rsv_addr;
  logic [N-1:0]    busy;
  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with busy-bit scoreboard; REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding
module regfile_mp_sb #(
  parameter int W        = 32,
  parameter int N        = 16,
  parameter int A        = $clog2(N),
  parameter int NR       = 2,
  parameter int NW       = 2,
  parameter int ZERO_REG = 0
) (
  input logic            clk,
  input logic            rst_n,
  regfile_mp_sb_if.slave bus
);
  logic [W-1:0] regs [N];
  logic [W-1:0] wd [N];
  logic [N-1:0] we;
  logic [N-1:0] set;
  logic [N-1:0] busy_q;
  logic [A-1:0] ra [NR];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      we[i] = 1'b0;
      wd[i] = '0;
      for (int p = NW - 1; p >= 0; p--)
        if (bus.wr_en[p] && bus.wr_addr[p*A +: A] == A'(i)) begin
          we[i] = 1'b1;
          wd[i] = bus.wr_data[p*W +: W];
        end
      set[i] = bus.rsv_en && bus.rsv_addr == A'(i);
      if (ZERO_REG != 0 && i == 0) begin
        we[i]  = 1'b0;
        set[i] = 1'b0;
      end
    end
  end
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int r = 0; r < NR; r++) begin
      ra[r] = bus.rd_addr[r*A +: A];
      if ({1'b0, ra[r]} < (A+1)'(N)) begin
        bus.rd_data[r*W +: W] = regs[ra[r]];
        bus.rd_busy[r]        = busy_q[ra[r]];
`ifdef REGFILE_BYPASS_EN
        if (we[ra[r]]) begin
          bus.rd_data[r*W +: W] = wd[ra[r]];
          bus.rd_busy[r]        = set[ra[r]];
        end
`endif
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) if (we[i]) regs[i] <= wd[i];
      busy_q <= set | (busy_q & ~we);
    end
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed checks of writes, conflicts, scoreboard, zero reg, out-of-range and reset
module tb_regfile_mp_sb;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int vectors = 0;
  int miscompares = 0;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  always #5 clk = ~clk;
  regfile_mp_sb_if #(.W(32), .N(16), .A(4), .NR(2), .NW(2)) ia ();
  regfile_mp_sb_if #(.W(16), .N(12), .A(4), .NR(2), .NW(2)) ib ();
  regfile_mp_sb #(.W(32), .N(16), .A(4), .NR(2), .NW(2), .ZERO_REG(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  regfile_mp_sb #(.W(16), .N(12), .A(4), .NR(2), .NW(2), .ZERO_REG(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    ia.wr_en = '0; ia.wr_addr = '0; ia.wr_data = '0; ia.rd_addr = '0; ia.rsv_en = 1'b0; ia.rsv_addr = '0;
    ib.wr_en = '0; ib.wr_addr = '0; ib.wr_data = '0; ib.rd_addr = '0; ib.rsv_en = 1'b0; ib.rsv_addr = '0;
    #1 rst_n = 1'b0;
    #1 ia.rd_addr = {4'd15, 4'd0};
    #1;
    chk("rst_rd", ia.rd_data, 64'h0);
    chk("rst_busy", ia.busy, 64'h0);
    chk("rst_rdbusy", ia.rd_busy, 64'h0);
    #7 rst_n = 1'b1;
    tick;
    ia.wr_en = 2'b11; ia.wr_addr = {4'd7, 4'd3}; ia.wr_data = {32'h22, 32'h11}; ia.rd_addr = {4'd7, 4'd3};
    #1;
    chk("par_pre", ia.rd_data, BYP ? {32'h22, 32'h11} : 64'h0);
    tick; ia.wr_en = '0; #1;
    chk("par", ia.rd_data, {32'h22, 32'h11});
    ia.wr_en = 2'b11; ia.wr_addr = {4'd5, 4'd5}; ia.wr_data = {32'h5555, 32'hAAAA};
    tick; ia.wr_en = '0; ia.rd_addr = {4'd3, 4'd5}; #1;
    chk("conflict", ia.rd_data, {32'h11, 32'hAAAA});
    ia.rsv_en = 1'b1; ia.rsv_addr = 4'd4;
    tick; ia.rsv_en = 1'b0; ia.rd_addr = {4'd3, 4'd4}; #1;
    chk("rsv_busy", ia.busy, 64'h0010);
    chk("rsv_rdbusy", ia.rd_busy, 64'b01);
    ia.wr_en = 2'b10; ia.wr_addr = {4'd4, 4'd0}; ia.wr_data = {32'h44, 32'h0};
    #1;
    chk("wr_rdbusy_pre", ia.rd_busy, BYP ? 64'b00 : 64'b01);
    chk("wr_rd_pre", ia.rd_data, {32'h11, BYP ? 32'h44 : 32'h0});
    tick; ia.wr_en = '0; #1;
    chk("clr_busy", ia.busy, 64'h0);
    chk("clr_rd", ia.rd_data, {32'h11, 32'h44});
    ia.wr_en = 2'b01; ia.wr_addr = {4'd0, 4'd4}; ia.wr_data = {32'h0, 32'h99}; ia.rsv_en = 1'b1; ia.rsv_addr = 4'd4;
    #1;
    chk("both_pre_rdbusy", ia.rd_busy, BYP ? 64'b01 : 64'b00);
    chk("both_pre_rd", ia.rd_data, {32'h11, BYP ? 32'h99 : 32'h44});
    tick; ia.wr_en = '0; ia.rsv_en = 1'b0; #1;
    chk("both_busy", ia.busy, 64'h0010);
    chk("both_rd", ia.rd_data, {32'h11, 32'h99});
    ia.wr_en = 2'b01; ia.wr_addr = {4'd0, 4'd9}; ia.wr_data = {32'h0, 32'h1111}; ia.rsv_en = 1'b1; ia.rsv_addr = 4'd9;
    tick; ia.wr_en = '0; ia.rsv_en = 1'b0; #1;
    chk("rsvwr_busy", ia.busy, 64'h0210);
    ia.wr_en = 2'b10; ia.wr_addr = {4'd9, 4'd0}; ia.wr_data = {32'h1234, 32'h0}; ia.rd_addr = {4'd4, 4'd9};
    #1;
    chk("byp_rd", ia.rd_data, {32'h99, BYP ? 32'h1234 : 32'h1111});
    chk("byp_rdbusy", ia.rd_busy, BYP ? 64'b10 : 64'b11);
    tick; ia.wr_en = '0; #1;
    chk("byp_post", ia.rd_data, {32'h99, 32'h1234});
    chk("byp_busy", ia.busy, 64'h0010);
    ib.wr_en = 2'b11; ib.wr_addr = {4'd11, 4'd0}; ib.wr_data = {16'hBEEF, 16'hFFFF};
    ib.rsv_en = 1'b1; ib.rsv_addr = 4'd0; ib.rd_addr = {4'd11, 4'd0};
    #1;
    chk("z_pre", ib.rd_data, {32'h0, BYP ? 16'hBEEF : 16'h0, 16'h0});
    tick; ib.wr_en = '0; ib.rsv_en = 1'b0; #1;
    chk("z_rd", ib.rd_data, {16'hBEEF, 16'h0});
    chk("z_busy", ib.busy, 64'h0);
    chk("z_rdbusy", ib.rd_busy, 64'h0);
    ib.wr_en = 2'b01; ib.wr_addr = {4'd0, 4'd13}; ib.wr_data = {16'h0, 16'h1234};
    ib.rsv_en = 1'b1; ib.rsv_addr = 4'd13; ib.rd_addr = {4'd13, 4'd11};
    #1;
    chk("oor_pre", ib.rd_data, {16'h0, 16'hBEEF});
    tick; ib.wr_en = '0; ib.rsv_en = 1'b0; #1;
    chk("oor_rd", ib.rd_data, {16'h0, 16'hBEEF});
    chk("oor_busy", ib.busy, 64'h0);
    ib.rsv_en = 1'b1; ib.rsv_addr = 4'd11;
    tick; ib.rsv_en = 1'b0; #1;
    chk("rsv11_rdbusy", ib.rd_busy, 64'b01);
    chk("rsv11_busy", ib.busy, 64'h800);
    for (int i = 0; i < 8; i++) begin
      ia.wr_en = 2'b11;
      ia.wr_addr = {4'(2*i+1), 4'(2*i)};
      ia.wr_data = {32'(2*i+101), 32'(2*i+100)};
      tick;
    end
    ia.wr_en = '0; ia.rsv_en = 1'b1; ia.rsv_addr = 4'd12;
    tick; ia.rsv_en = 1'b0; ia.rd_addr = {4'd15, 4'd0}; #1;
    chk("fill_rd", ia.rd_data, {32'd115, 32'd100});
    chk("fill_busy", ia.busy, 64'h1000);
    ia.wr_en = 2'b01; ia.wr_addr = {4'd0, 4'd1}; ia.wr_data = {32'h0, 32'hDEAD};
    ia.rsv_en = 1'b1; ia.rsv_addr = 4'd2;
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_rd", ia.rd_data, 64'h0);
    chk("mrst_busy", ia.busy, 64'h0);
    chk("mrst_zb", ib.busy, 64'h0);
    tick; ia.wr_en = '0; ia.rsv_en = 1'b0; ia.rd_addr = {4'd2, 4'd1}; #1;
    chk("mrst_hold_rd", ia.rd_data, 64'h0);
    chk("mrst_hold_busy", ia.busy, 64'h0);
    rst_n = 1'b1;
    ia.wr_en = 2'b10; ia.wr_addr = {4'd2, 4'd0}; ia.wr_data = {32'h77, 32'h0};
    tick; ia.wr_en = '0; #1;
    chk("post_rst_rd", ia.rd_data, {32'h77, 32'h0});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
